// File: rtl/step_clock_gen.sv
// rtl/step_clock_gen.sv - debounced single-step / free-run CPU clock generator
//
// Turns a raw, bouncy step push-button into one clean fixed-width clock pulse
// per accepted press. It can also free-run the CPU at a fixed step period.
// A one-cycle step strobe and a wrapping step counter feed the display path.
//
// Ports:
//   clk         in   1        system clock, all logic on the rising edge
//   nRST        in   1        synchronous active-low reset
//   key_in      in   1        raw step button (1 = pressed), asynchronous, bouncy
//   run_sw      in   1        mode switch, asynchronous (0 = manual, 1 = free run)
//   step_clk    out  1        registered CPU clock, HIGH_CYCLES wide per step
//   step_pulse  out  1        one-cycle strobe on the step_clk rising cycle
//   step_count  out  COUNT_W  steps issued since reset, wraps
//   key_state   out  1        debounced key level

module step_clock_gen #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HIGH_CYCLES     = 16,
    parameter int AUTO_PERIOD     = 50_000_000,
    parameter int COUNT_W         = 16
) (
    input  logic               clk,
    input  logic               nRST,
    input  logic               key_in,
    input  logic               run_sw,
    output logic               step_clk,
    output logic               step_pulse,
    output logic [COUNT_W-1:0] step_count,
    output logic               key_state
);

    localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HIGH_W = (HIGH_CYCLES > 1) ? $clog2(HIGH_CYCLES) : 1;
    localparam int PER_W  = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HIGH_W-1:0] HIGH_LAST = HIGH_W'(HIGH_CYCLES - 1);
    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(AUTO_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronizers for the asynchronous button and switch.
    // rs_prev is one more stage so a change of mode can be detected.
    // ------------------------------------------------------------------
    logic key_meta;
    logic ks;
    logic run_meta;
    logic rs;
    logic rs_prev;

    always_ff @(posedge clk) begin
        if (!nRST) begin
            key_meta <= 1'b0;
            ks       <= 1'b0;
            run_meta <= 1'b0;
            rs       <= 1'b0;
            rs_prev  <= 1'b0;
        end else begin
            key_meta <= key_in;
            ks       <= key_meta;
            run_meta <= run_sw;
            rs       <= run_meta;
            rs_prev  <= rs;
        end
    end

    // ------------------------------------------------------------------
    // Debounce FSM. A new key level is accepted only after the synchronized
    // key has held it through a full DEBOUNCE_CYCLES window; any glitch back
    // to the old level restarts the wait from the stable state.
    // ------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic [DEB_W-1:0] cnt_q;
    logic [DEB_W-1:0] cnt_d;
    logic             key_d;
    logic             press_req;

    always_ff @(posedge clk) begin
        if (!nRST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            key_state <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            key_state <= key_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        key_d     = key_state;
        press_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (ks) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!ks) begin
                    state_d = IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = HELD;
                    key_d     = 1'b1;
                    // Only the IDLE->HELD path requests a step, so holding
                    // the key can never repeat it.
                    press_req = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!ks) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (ks) begin
                    state_d = HELD;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                    key_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Free-run period counter. It only counts while run mode has been
    // stable for at least one cycle, so entering run mode always starts a
    // full period rather than firing on a stale count.
    // ------------------------------------------------------------------
    logic [PER_W-1:0] pcnt_q;
    logic             auto_hit;

    assign auto_hit = rs && rs_prev && (pcnt_q == PER_LAST);

    always_ff @(posedge clk) begin
        if (!nRST) begin
            pcnt_q <= '0;
        end else if (!rs || !rs_prev || auto_hit) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_q + 1'b1;
        end
    end

    // Registered request: the mode mux picks exactly one source, so a key
    // press during run mode never reaches the pulse generator.
    logic step_req_q;

    always_ff @(posedge clk) begin
        if (!nRST) begin
            step_req_q <= 1'b0;
        end else begin
            step_req_q <= rs ? auto_hit : press_req;
        end
    end

    // ------------------------------------------------------------------
    // Pulse generator. While step_clk is high every request is dropped;
    // the high counter runs the pulse to completion regardless of mode.
    // ------------------------------------------------------------------
    logic [HIGH_W-1:0] hcnt_q;

    always_ff @(posedge clk) begin
        if (!nRST) begin
            step_clk   <= 1'b0;
            step_pulse <= 1'b0;
            step_count <= '0;
            hcnt_q     <= '0;
        end else if (step_clk) begin
            step_pulse <= 1'b0;
            if (hcnt_q == '0) begin
                step_clk <= 1'b0;
            end else begin
                hcnt_q <= hcnt_q - 1'b1;
            end
        end else if (step_req_q) begin
            step_clk   <= 1'b1;
            step_pulse <= 1'b1;
            hcnt_q     <= HIGH_LAST;
            step_count <= step_count + 1'b1;
        end else begin
            step_pulse <= 1'b0;
        end
    end

endmodule
